mult_seq: RTL and testbench

MULT_SEQ -- requirements
Module: mult_seq

---
 rtl/mult_seq.sv | 172 +++++++++++++++++
 tb/tb_mult_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq.sv
// Sequential 32x32 signed multiplier using radix-2 Booth recoding over 32 cycles.
// Define MULT_OVERFLOW_DETECT_EN to flag products that do not fit in signed 32 bits.

module mult_seq_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        ovf
);

  logic carry_s;
  logic c_msb_s;

  // Ripple-carry chain; the carry into the MSB is kept to derive signed overflow.
  always_comb begin
    carry_s = cin;
    sum     = 32'd0;
    for (int i = 0; i < 31; i++) begin
      sum[i]  = a[i] ^ b[i] ^ carry_s;
      carry_s = (a[i] & b[i]) | (carry_s & (a[i] ^ b[i]));
    end
    c_msb_s = carry_s;
    sum[31] = a[31] ^ b[31] ^ carry_s;
    carry_s = (a[31] & b[31]) | (carry_s & (a[31] ^ b[31]));
    ovf     = carry_s ^ c_msb_s;
  end

endmodule

module mult_seq (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] m_q, m_d;
  logic [64:0] prod_q, prod_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic        rdy_q, rdy_d;
  logic        busy_q, busy_d;

  logic [31:0] addend_s;
  logic        cin_s;
  logic [31:0] sum_s;
  logic        ovf_s;
  logic        sign_s;
  logic [64:0] prod_nxt_s;

  // Booth recoding of {P_lo[0], q}: add M, subtract M (~M + 1) or pass P_hi through.
  always_comb begin
    case (prod_q[1:0])
      2'b01:   begin addend_s = m_q;   cin_s = 1'b0; end
      2'b10:   begin addend_s = ~m_q;  cin_s = 1'b1; end
      default: begin addend_s = 32'd0; cin_s = 1'b0; end
    endcase
  end

  mult_seq_adder u_adder (
    .a   (prod_q[64:33]),
    .b   (addend_s),
    .cin (cin_s),
    .sum (sum_s),
    .ovf (ovf_s)
  );

  // The true sign of the 33-bit sum is shifted in, so -(0x80000000) is not lost.
  assign sign_s     = sum_s[31] ^ ovf_s;
  assign prod_nxt_s = {sign_s, sum_s, prod_q[32:1]};

`ifdef MULT_OVERFLOW_DETECT_EN
  logic exc_q, exc_d;

  function automatic logic overflow_chk(input logic [64:0] p);
    return (p[64:33] != {32{p[32]}});
  endfunction
`endif

  // Next-state, datapath and output-register logic.
  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    rdy_d    = 1'b0;
`ifdef MULT_OVERFLOW_DETECT_EN
    exc_d    = exc_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (ctrl_MULT) begin
          state_d = S_BUSY;
          m_d     = data_operandA;
          prod_d  = {32'd0, data_operandB, 1'b0};
          cnt_d   = 5'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        prod_d = prod_nxt_s;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d  = S_DONE;
          result_d = prod_nxt_s[32:1];
          rdy_d    = 1'b1;
`ifdef MULT_OVERFLOW_DETECT_EN
          exc_d    = overflow_chk(prod_nxt_s);
`endif
        end else begin
          state_d = S_BUSY;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_BUSY);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      m_q      <= 32'd0;
      prod_q   <= 65'd0;
      cnt_q    <= 5'd0;
      result_q <= 32'd0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
`ifdef MULT_OVERFLOW_DETECT_EN
      exc_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
`ifdef MULT_OVERFLOW_DETECT_EN
      exc_q    <= exc_d;
`endif
    end
  end

  assign data_result    = result_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;
`ifdef MULT_OVERFLOW_DETECT_EN
  assign data_exception = exc_q;
`else
  assign data_exception = 1'b0;
`endif

endmodule

// File: tb/tb_mult_seq.sv
// Directed scoreboard bench for mult_seq: latency, results, overflow flag, abort and back-to-back.
module tb_mult_seq;

  logic        clock;
  logic        reset_n;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  typedef struct packed {
    logic [31:0] res;
    logic        exc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_bad    = 0;

`ifdef MULT_OVERFLOW_DETECT_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  mult_seq dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    exp_t e;
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    e.res = p[31:0];
    e.exc = OVF_EN && ((p > 64'sd2147483647) || (p < -64'sd2147483648));
    return e;
  endfunction

  // Drive a start pulse for one edge, then scramble operands to prove they were latched.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic ee, input bit push_exp);
    exp_t e;
    e.res = er;
    e.exc = ee;
    if (push_exp) sb.push_back(e);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = 1'b1;
    tick();
    ctrl_MULT     = 1'b0;
    data_operandA = ~a;
    data_operandB = b + 32'd7;
    chk1("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_rdy(input int exp_lat, input string tag);
    int   lat;
    exp_t e;
    lat = 0;
    e   = '0;
    while (data_resultRDY !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    chk32({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    if (sb.size() > 0) e = sb.pop_front();
    chk1({tag, "_rdy"}, data_resultRDY, 1'b1);
    chk32({tag, "_result"}, data_result, e.res);
    chk1({tag, "_exception"}, data_exception, e.exc);
    chk1({tag, "_busy_at_rdy"}, busy, 1'b0);
  endtask

  task automatic finish_idle(input string tag, input logic [31:0] held);
    tick();
    chk1({tag, "_rdy_pulse"}, data_resultRDY, 1'b0);
    chk1({tag, "_idle_busy"}, busy, 1'b0);
    chk32({tag, "_held"}, data_result, held);
  endtask

  logic [31:0] ta [10];
  logic [31:0] tb_v [10];
  logic [31:0] tr [10];
  logic        te [10];

  initial begin
    exp_t e;
    logic [31:0] ra, rb;
    bit saw_rdy;

    reset_n       = 1'b0;
    ctrl_MULT     = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    tick();
    tick();
    chk32("reset_result", data_result, 32'd0);
    chk1("reset_exception", data_exception, 1'b0);
    chk1("reset_rdy", data_resultRDY, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    reset_n = 1'b1;
    tick();

    ta[0] = 32'd3;          tb_v[0] = 32'd4;          tr[0] = 32'h0000000C; te[0] = 1'b0;
    ta[1] = 32'hFFFFFFF9;   tb_v[1] = 32'd6;          tr[1] = 32'hFFFFFFD6; te[1] = 1'b0;
    ta[2] = 32'h7FFFFFFF;   tb_v[2] = 32'd2;          tr[2] = 32'hFFFFFFFE; te[2] = OVF_EN;
    ta[3] = 32'h80000000;   tb_v[3] = 32'hFFFFFFFF;   tr[3] = 32'h80000000; te[3] = OVF_EN;
    ta[4] = 32'hFFFFFFFF;   tb_v[4] = 32'hFFFFFFFF;   tr[4] = 32'h00000001; te[4] = 1'b0;
    ta[5] = 32'h80000000;   tb_v[5] = 32'h80000000;   tr[5] = 32'h00000000; te[5] = OVF_EN;
    ta[6] = 32'h00010000;   tb_v[6] = 32'h00010000;   tr[6] = 32'h00000000; te[6] = OVF_EN;
    ta[7] = 32'hFFFF0000;   tb_v[7] = 32'h00010000;   tr[7] = 32'h00000000; te[7] = OVF_EN;
    ta[8] = 32'h80000000;   tb_v[8] = 32'd1;          tr[8] = 32'h80000000; te[8] = 1'b0;
    ta[9] = 32'd0;          tb_v[9] = 32'h80000000;   tr[9] = 32'h00000000; te[9] = 1'b0;

    for (int i = 0; i < 10; i++) begin
      start_op(ta[i], tb_v[i], tr[i], te[i], 1'b1);
      wait_rdy(32, $sformatf("dir%0d", i));
      finish_idle($sformatf("dir%0d", i), tr[i]);
    end

    for (int i = 0; i < 6; i++) begin
      ra = $urandom();
      rb = (i < 3) ? $urandom_range(0, 65535) : $urandom();
      e  = model(ra, rb);
      start_op(ra, rb, e.res, e.exc, 1'b1);
      wait_rdy(32, $sformatf("rnd%0d", i));
      finish_idle($sformatf("rnd%0d", i), e.res);
    end

    // A second start while iterating must neither restart nor reload operands.
    start_op(32'd5, 32'd5, 32'd25, 1'b0, 1'b1);
    repeat (10) tick();
    data_operandA = 32'd9;
    ctrl_MULT     = 1'b1;
    tick();
    ctrl_MULT     = 1'b0;
    chk1("ignore_busy", busy, 1'b1);
    wait_rdy(21, "ignore");
    finish_idle("ignore", 32'd25);

    // Reset mid-operation clears everything immediately and produces no result.
    start_op(32'd5, 32'd5, 32'd25, 1'b0, 1'b0);
    repeat (10) tick();
    reset_n = 1'b0;
    #1;
    chk32("abort_result", data_result, 32'd0);
    chk1("abort_exception", data_exception, 1'b0);
    chk1("abort_rdy", data_resultRDY, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    tick();
    reset_n = 1'b1;
    saw_rdy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (data_resultRDY === 1'b1) saw_rdy = 1'b1;
      else saw_rdy = saw_rdy;
    end
    chk1("abort_no_rdy", saw_rdy, 1'b0);
    chk1("abort_idle_busy", busy, 1'b0);

    // ctrl_MULT held high: DONE goes straight back to BUSY, one result every 33 cycles.
    e.res = 32'd6;
    e.exc = 1'b0;
    sb.push_back(e);
    sb.push_back(e);
    sb.push_back(e);
    data_operandA = 32'd2;
    data_operandB = 32'd3;
    ctrl_MULT     = 1'b1;
    tick();
    chk1("b2b_busy_start", busy, 1'b1);
    wait_rdy(32, "b2b0");
    tick();
    chk1("b2b0_rdy_fall", data_resultRDY, 1'b0);
    chk1("b2b0_restart_busy", busy, 1'b1);
    wait_rdy(32, "b2b1");
    tick();
    chk1("b2b1_rdy_fall", data_resultRDY, 1'b0);
    chk1("b2b1_restart_busy", busy, 1'b1);
    wait_rdy(32, "b2b2");
    ctrl_MULT = 1'b0;
    finish_idle("b2b2", 32'd6);
    chk32("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
